// File: rtl/fp_normalize_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared types and constants for the FP normalise/round stage.
// Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SHIFT = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } norm_state_t;

    localparam logic [7:0] EXP_MAX  = 8'hFF;
    localparam int         EXP_BIAS = 127;

    // Bit positions inside the raw {carry, hidden, fraction, guard, sticky} word
    localparam int RAW_CARRY   = 26;
    localparam int RAW_HIDDEN  = 25;
    localparam int RAW_FRAC_HI = 24;
    localparam int RAW_FRAC_LO = 2;
    localparam int RAW_GUARD   = 1;
    localparam int RAW_STICKY  = 0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage
`default_nettype wire

// File: rtl/fp_normalize_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize_if
// Purpose  : Start/done request bus between the adder datapath and normaliser.
// Revision : 1.0  initial release
// ============================================================================
interface fp_normalize_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int RAW_W = MAN_W + 4
);
    logic             norm_start;
    logic             norm_sign;
    logic [EXP_W-1:0] norm_exp;
    logic [RAW_W-1:0] norm_frac;
    logic             norm_busy;
    logic             norm_done;
    logic [31:0]      norm_result;
    logic             norm_overflow;
    logic             norm_underflow;

    modport master (
        output norm_start, norm_sign, norm_exp, norm_frac,
        input  norm_busy, norm_done, norm_result, norm_overflow, norm_underflow
    );

    modport slave (
        input  norm_start, norm_sign, norm_exp, norm_frac,
        output norm_busy, norm_done, norm_result, norm_overflow, norm_underflow
    );
endinterface
`default_nettype wire

// File: rtl/fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : fp_round
// Purpose  : Combinational round-to-nearest-even incrementer.
// Revision : 1.0  initial release
// ============================================================================
module fp_round #(
    parameter int MAN_W = 23
) (
    input  wire logic [MAN_W+2:0] i_raw,    // {hidden, fraction, guard, sticky}
    output logic      [MAN_W:0]   o_man,
    output logic                  o_carry
);
    logic w_round_up;

    assign w_round_up       = i_raw[1] & (i_raw[0] | i_raw[2]);
    assign {o_carry, o_man} = {1'b0, i_raw[MAN_W+2:2]} + {{(MAN_W+1){1'b0}}, w_round_up};
endmodule
`default_nettype wire

// File: rtl/fp_normalize.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize
// Purpose  : Multi-cycle normalise/round stage producing IEEE-754 single, RNE.
//            Define NORM_DENORM_EN to keep denormal results instead of flushing.
// Revision : 1.0  initial release
// ============================================================================
module fp_normalize
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int RAW_W = MAN_W + 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fp_normalize_if.slave   bus
);
    norm_state_t      r_state;
    logic             r_sign;
    logic [EXP_W-1:0] r_exp;
    logic [RAW_W-1:0] r_frac;
    fp32_t            r_pend;
    logic             r_pend_ovf;
    logic             r_pend_unf;
    fp32_t            r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic             r_unf;

    logic [MAN_W:0]   w_rnd_man;
    logic             w_rnd_carry;
    logic             w_rnd_ovf;
    logic             w_rnd_unf;
    fp32_t            w_rnd_res;

    fp_round #(.MAN_W(MAN_W)) u_round (
        .i_raw   (r_frac[RAW_HIDDEN:0]),
        .o_man   (w_rnd_man),
        .o_carry (w_rnd_carry)
    );

    // A rounded mantissa without its hidden bit is a denormal: exponent field 0
    always_comb begin
        w_rnd_ovf = (r_exp == EXP_MAX) || (w_rnd_carry && (r_exp == EXP_MAX - 8'd1));
        w_rnd_unf = !w_rnd_carry && !w_rnd_man[MAN_W] &&
                    (r_frac[RAW_GUARD] | r_frac[RAW_STICKY]);
        w_rnd_res.sign = r_sign;
        if (w_rnd_ovf) begin
            w_rnd_res.exp  = EXP_MAX;
            w_rnd_res.frac = '0;
        end else if (w_rnd_carry) begin
            w_rnd_res.exp  = r_exp + EXP_W'(1);
            w_rnd_res.frac = '0;
        end else begin
            w_rnd_res.exp  = w_rnd_man[MAN_W] ? r_exp : '0;
            w_rnd_res.frac = w_rnd_man[MAN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_frac     <= '0;
            r_pend     <= '0;
            r_pend_ovf <= 1'b0;
            r_pend_unf <= 1'b0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (bus.norm_start) begin
                        r_busy     <= 1'b1;
                        r_ovf      <= 1'b0;
                        r_unf      <= 1'b0;
                        r_pend_ovf <= 1'b0;
                        r_pend_unf <= 1'b0;
                        r_sign     <= bus.norm_sign;
                        r_exp      <= bus.norm_exp;
                        r_frac     <= bus.norm_frac;
                        r_state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (r_frac == '0) begin
                        r_pend  <= '0;
                        r_state <= DONE;
                    end else if (r_exp == EXP_MAX) begin
                        r_pend     <= '{sign: r_sign, exp: EXP_MAX, frac: '0};
                        r_pend_ovf <= 1'b1;
                        r_state    <= DONE;
                    end else if (r_frac[RAW_CARRY]) begin
                        r_frac  <= {1'b0, r_frac[RAW_CARRY:RAW_FRAC_LO],
                                    r_frac[RAW_GUARD] | r_frac[RAW_STICKY]};
                        r_exp   <= r_exp + EXP_W'(1);
                        r_state <= ROUND;
                    end else if (r_frac[RAW_HIDDEN]) begin
                        r_state <= ROUND;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_exp <= EXP_W'(1)) begin
`ifdef NORM_DENORM_EN
                        r_state <= ROUND;
`else
                        r_pend     <= '{sign: r_sign, exp: '0, frac: '0};
                        r_pend_unf <= 1'b1;
                        r_state    <= DONE;
`endif
                    end else begin
                        r_frac <= r_frac << 1;
                        r_exp  <= r_exp - EXP_W'(1);
                        if (r_frac[RAW_FRAC_HI]) begin
                            r_state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    r_pend     <= w_rnd_res;
                    r_pend_ovf <= w_rnd_ovf;
                    r_pend_unf <= w_rnd_unf;
                    r_state    <= DONE;
                end
                DONE: begin
                    r_result <= r_pend;
                    r_ovf    <= r_pend_ovf;
                    r_unf    <= r_pend_unf;
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.norm_busy      = r_busy;
    assign bus.norm_done      = r_done;
    assign bus.norm_result    = r_result;
    assign bus.norm_overflow  = r_ovf;
    assign bus.norm_underflow = r_unf;
endmodule
`default_nettype wire

// File: doc/fp_normalize.md
Name: fp_normalize

Overview:
- Multi-cycle normalise/round stage directly downstream of the FP add/subtract datapath.
- Consumes the raw sign, pre-normalisation exponent and extended mantissa sum (carry, hidden, fraction, guard, sticky).
- Produces an IEEE-754 single-precision word using round-to-nearest-even, plus overflow/underflow flags.
- Uses a start/done handshake, one left shift per cycle.

Parameters:
EXP_W, 8, exponent width
MAN_W, 23, stored fraction width
RAW_W, MAN_W+4, raw mantissa width: {carry, hidden, fraction, guard, sticky}

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
norm_start  in  1  accept request when idle
norm_sign  in  1  result sign
norm_exp  in  EXP_W  exponent of the larger operand
norm_frac  in  RAW_W  [26]=carry, [25]=hidden, [24:2]=fraction, [1]=guard, [0]=sticky
norm_busy  out  1  high from acceptance until the cycle norm_done is high, inclusive
norm_done  out  1  one-cycle pulse; result valid
norm_result  out  32  {sign, exp, fraction}
norm_overflow  out  1  valid with done
norm_underflow  out  1  valid with done

Behaviour:
- Reset: clk and rst only; rst sampled on posedge clk, active-high, synchronous.
  - All outputs are 0 and state returns to IDLE.
  - Reset mid-operation aborts; no done pulse is issued.
- IDLE: when norm_start=1, latch inputs and go to CHECK. norm_start is ignored while norm_busy=1.
- CHECK:
  - frac==0: result {1'b0, 31'b0}, go to DONE.
  - norm_exp==255: result {sign, 8'hFF, 0}, overflow=1, go to DONE.
  - carry=1: shift right 1, sticky |= dropped bit, exp+1, go to ROUND.
  - hidden=1: go to ROUND.
  - Otherwise: go to SHIFT.
- SHIFT: each cycle shift frac left 1 and decrement exp.
  - Go to ROUND once hidden=1.
  - If hidden=0 and exp==1: flush to {sign, 31'b0} with underflow=1, go to DONE.
- ROUND:
  - round_up = guard & (sticky | frac[2]); add round_up to {hidden, fraction}.
  - Carry-out renormalises: fraction=0, exp+1.
  - exp==255 after this step: result {sign, 8'hFF, 0}, overflow=1.
  - Go to DONE.
- DONE:
  - Registers update on entry.
  - norm_done=1 for exactly one cycle; norm_busy deasserts the next cycle; return to IDLE.
  - A new start is accepted in the cycle after done.
- Outputs hold their value until the next DONE.
- Flags clear at the next acceptance.
- Latency, in cycles from the start edge to norm_done high:
  - zero or exp==255 input: 2
  - normalised or carry input: 3
  - k left shifts: 3+k, with k ≤ 25

Optional Feature:
Macro NORM_DENORM_EN.
- Defined: SHIFT stops when exp==1 with hidden=0.
  - Result is encoded with exponent 0 (denormal) and rounded normally.
  - A round carry into the hidden bit yields exp=1.
  - underflow=1 if the result is denormal and guard|sticky was set before rounding.
- Undefined: flush-to-zero as in Behaviour.

Decomposition:
- Package fp_pkg holds:
  - state enum norm_state_t {IDLE, CHECK, SHIFT, ROUND, DONE}
  - EXP_MAX=8'hFF, EXP_BIAS=127
  - raw-field bit-index constants
  - fp32_t packed struct {sign, exp, frac}
- One sub-module: fp_round, combinational RNE incrementer.
  - Inputs: {hidden, fraction, guard, sticky}.
  - Outputs: rounded 24-bit mantissa and carry-out.
  - Instantiated in ROUND.

Test Plan:
- 1.25+1.5: sign0, exp 127, frac[26]=1, frac[24:23]=2'b11, rest 0 -> 0x40300000, flags 0, done 3 cycles after start.
- 1.5-1.25: sign0, exp 127, only frac[23]=1 -> 2 shifts, 0x3E800000, done 5 cycles after start.
- RNE tie: exp 127, hidden=1.
  - fraction=0, guard=1, sticky=0 -> 0x3F800000.
  - fraction=1, guard=1 -> 0x3F800002.
  - fraction=0, guard=1, sticky=1 -> 0x3F800001.
- Overflow: exp 254, carry=1 -> 0x7F800000, norm_overflow=1.
- Exact cancel / underflow:
  - frac=0 -> 0x00000000, done 2 cycles after start.
  - exp 1, only frac[24]=1, sign0 -> 0x00000000, underflow=1 without the macro; 0x00400000 with NORM_DENORM_EN.
- Handshake/reset:
  - norm_start pulsed during SHIFT is ignored; the first result is unchanged.
  - rst asserted mid-SHIFT -> next cycle busy=0, result=0, no done.
  - Restart immediately after reset works.
